imem_port_arbiter: RTL and testbench
====================================

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- ADDR_WIDTH, 10, instruction memory word-address width.
- DATA_WIDTH, 16, instruction word width.
- READ_LATENCY, 2, memory read latency in clocks; 2 = registered-output memory, 1 = unregistered.

REQ-002 Ports, one per line: name, direction, width, meaning. One clock; reset is synchronous and active-high.
- i_clk, in, 1, single clock; all logic on its rising edge.
- i_reset, in, 1, synchronous active-high reset.
- i_f_req, in, 1, fetch read request.
- i_f_addr, in, ADDR_WIDTH, fetch word address.
- o_f_gnt, out, 1, fetch request accepted this cycle.
- o_f_rvalid, out, 1, fetch read data valid.
- o_f_rdata, out, DATA_WIDTH, fetch read data.
- i_l_req, in, 1, loader (debug unit) request.
- i_l_we, in, 1, loader write (1) or read (0).
- i_l_addr, in, ADDR_WIDTH, loader word address.
- i_l_wdata, in, DATA_WIDTH, loader write data.
- o_l_gnt, out, 1, loader request accepted this cycle.
- o_l_rvalid, out, 1, loader read data valid.
- o_l_rdata, out, DATA_WIDTH, loader read data.
- i_halt, in, 1, debug unit requests fetch suspension.
- o_halted, out, 1, fetch suspended and no fetch read in flight.
- o_mem_addr, out, ADDR_WIDTH, memory address (registered).
- o_mem_we, out, 1, memory write enable (registered).
- o_mem_wdata, out, DATA_WIDTH, memory write data (registered).
- i_mem_rdata, in, DATA_WIDTH, memory read data.

Function
REQ-003 At most one request SHALL be granted per cycle; a grant is combinational (req and selected) and a handshake completes in a cycle where req and gnt are both high.
REQ-004 A requester SHALL hold req, addr, we and wdata stable until granted; the arbiter SHALL not grant a deasserted req.
REQ-005 Granted address, we and wdata SHALL appear on o_mem_addr, o_mem_we and o_mem_wdata in the cycle after the handshake; o_mem_we SHALL be 0 in every cycle without a granted write.
REQ-006 Each granted read SHALL push an owner tag (F or L) into a READ_LATENCY+1 deep tag pipeline; writes push "none".
REQ-007 The owner's rvalid SHALL assert for exactly one cycle, READ_LATENCY+1 cycles after the handshake cycle; the corresponding rdata SHALL equal i_mem_rdata in that cycle and SHALL be 0 otherwise.
REQ-008 Back-to-back grants SHALL be supported (one per cycle); responses SHALL return in grant order without loss, including reads interleaved with writes.
REQ-009 Fetch-gating FSM states and transitions:
- RUN: fetch is eligible. i_halt=1 -> DRAIN.
- DRAIN: fetch not granted. No F tag in pipeline -> HALT. i_halt=0 -> RUN.
- HALT: o_halted=1, fetch not granted. i_halt=0 -> RUN.
REQ-010 Loader requests SHALL be serviceable in all FSM states.
REQ-011 A loader write to address A followed by a fetch read of A SHALL return the new data (write-before-read in grant order).
REQ-012 In RUN, with only one requester active, that requester SHALL be granted every cycle it requests.

Reset
REQ-013 While i_reset=1 (sampled at a clock edge), all of the following SHALL hold:
- o_f_gnt, o_l_gnt, o_f_rvalid, o_l_rvalid, o_mem_we, o_halted SHALL be 0.
- o_mem_addr, o_mem_wdata, o_f_rdata, o_l_rdata SHALL be 0.
- FSM SHALL be RUN and the round-robin pointer SHALL favour the loader.
REQ-014 Reset mid-operation SHALL clear the tag pipeline; no rvalid SHALL assert for reads granted before reset.

Configuration
REQ-015 Macro IMEM_ARB_RR_EN defined: on simultaneous F and L requests in RUN, grants SHALL alternate.
- The most recently granted contender on a conflict loses the next conflict.
- Non-conflict grants SHALL not move the pointer.
REQ-016 Macro IMEM_ARB_RR_EN undefined: the loader SHALL have fixed priority over fetch on every conflict.

Verification
REQ-017 Fetch reads 0x000..0x003 back-to-back, READ_LATENCY=2: o_f_gnt high 4 cycles; o_f_rvalid high 4 cycles starting 3 cycles after first grant; data equals preloaded words in order.
REQ-018 Loader writes 0xBEEF to 0x010, then fetch reads 0x010: o_mem_we=1 for one cycle with addr 0x010; o_f_rdata=0xBEEF.
REQ-019 F and L request continuously for 6 cycles:
- With IMEM_ARB_RR_EN: grants alternate L,F,L,F,L,F.
- Without IMEM_ARB_RR_EN: L granted 6 times, F none.
REQ-020 i_halt=1 one cycle after a fetch grant: FSM goes DRAIN; o_halted asserts one cycle after that fetch's o_f_rvalid; no further o_f_gnt; loader read of 0x010 during HALT returns 0xBEEF on o_l_rvalid.
REQ-021 i_reset pulsed 1 cycle after two fetch grants: no o_f_rvalid afterwards; all outputs 0; FSM RUN.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - fetch/loader arbiter for the instruction memory port; IMEM_ARB_RR_EN selects round-robin conflict arbitration
module imem_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_f_req,
  input  logic [ADDR_WIDTH-1:0] i_f_addr,
  output logic                  o_f_gnt,
  output logic                  o_f_rvalid,
  output logic [DATA_WIDTH-1:0] o_f_rdata,
  input  logic                  i_l_req,
  input  logic                  i_l_we,
  input  logic [ADDR_WIDTH-1:0] i_l_addr,
  input  logic [DATA_WIDTH-1:0] i_l_wdata,
  output logic                  o_l_gnt,
  output logic                  o_l_rvalid,
  output logic [DATA_WIDTH-1:0] o_l_rdata,
  input  logic                  i_halt,
  output logic                  o_halted,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  // One stage for the registered address plus READ_LATENCY memory stages.
  localparam int TAG_DEPTH = READ_LATENCY + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_F    = 2'd1,
    TAG_L    = 2'd2
  } tag_e;

  state_e                state_q;
  state_e                state_d;
  tag_e                  tag_q [TAG_DEPTH];
  tag_e                  tag_in;
  logic                  f_gnt;
  logic                  l_gnt;
  logic                  f_eligible;
  logic                  conflict;
  logic                  f_in_flight;
  logic                  f_rvalid;
  logic                  l_rvalid;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  mem_we_q;
  logic                  mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
`ifdef IMEM_ARB_RR_EN
  // 1: fetch wins the next conflict, 0: loader wins it.
  logic                  rr_f_q;
  logic                  rr_f_d;
`endif

  // Fetch may only compete while the gating FSM is running; nothing is granted in reset.
  assign f_eligible = (state_q == ST_RUN);
  assign conflict   = !i_reset && i_f_req && i_l_req && f_eligible;

  // Combinational grant: at most one requester per cycle, never a deasserted one.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (conflict) begin
`ifdef IMEM_ARB_RR_EN
      f_gnt = rr_f_q;
      l_gnt = !rr_f_q;
`else
      l_gnt = 1'b1;
`endif
    end else if (!i_reset) begin
      f_gnt = i_f_req && f_eligible;
      l_gnt = i_l_req;
    end
  end

`ifdef IMEM_ARB_RR_EN
  // The winner of a conflict loses the next one; uncontended grants leave the pointer alone.
  always_comb begin
    rr_f_d = rr_f_q;
    if (conflict) begin
      rr_f_d = l_gnt;
    end
  end

  // Round-robin pointer register, loader favoured out of reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_f_q <= 1'b0;
    end else begin
      rr_f_q <= rr_f_d;
    end
  end
`endif

  // Next memory command: the granted request, write enable dropped on idle cycles.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (l_gnt) begin
      mem_addr_d  = i_l_addr;
      mem_we_d    = i_l_we;
      mem_wdata_d = i_l_we ? i_l_wdata : '0;
    end else if (f_gnt) begin
      mem_addr_d  = i_f_addr;
      mem_wdata_d = '0;
    end
  end

  // Registered memory command port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Owner tag for this cycle's handshake; writes return nothing.
  always_comb begin
    tag_in = TAG_NONE;
    if (l_gnt && !i_l_we) begin
      tag_in = TAG_L;
    end else if (f_gnt) begin
      tag_in = TAG_F;
    end
  end

  // Tag pipeline tracking reads in flight; reset drops any outstanding response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < TAG_DEPTH; k++) begin
        tag_q[k] <= TAG_NONE;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int k = 1; k < TAG_DEPTH; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // A fetch read still in flight after this cycle (the last stage completes now).
  always_comb begin
    f_in_flight = 1'b0;
    for (int k = 0; k < TAG_DEPTH - 1; k++) begin
      if (tag_q[k] == TAG_F) begin
        f_in_flight = 1'b1;
      end
    end
  end

  // Fetch-gating FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_halt) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!i_halt) begin
          state_d = ST_RUN;
        end else if (!f_in_flight) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!i_halt) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Fetch-gating FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Response steering from the last tag stage; data is zero unless valid.
  always_comb begin
    f_rvalid = !i_reset && (tag_q[TAG_DEPTH-1] == TAG_F);
    l_rvalid = !i_reset && (tag_q[TAG_DEPTH-1] == TAG_L);
  end

  assign o_f_gnt     = f_gnt;
  assign o_l_gnt     = l_gnt;
  assign o_f_rvalid  = f_rvalid;
  assign o_l_rvalid  = l_rvalid;
  assign o_f_rdata   = f_rvalid ? i_mem_rdata : '0;
  assign o_l_rdata   = l_rvalid ? i_mem_rdata : '0;
  assign o_halted    = !i_reset && (state_q == ST_HALT);
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  logic          halt;
  logic          halted;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  imem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt), .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
    .i_halt(halt), .o_halted(halted),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    return 16'hA000 + DW'(a * 3);
  endfunction

  // Memory model: writes land at the edge, reads return RL edges after the address.
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_pipe [RL];
  logic          mem_ready = 1'b0;
  assign mem_rdata = rd_pipe[RL-1];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!mem_ready) begin
      for (int a = 0; a < (1<<AW); a++) mem[a] <= init_word(a);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  typedef struct {
    logic          is_l;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t          sbq[$];
  logic [DW-1:0] shadow [1<<AW];

  // Scoreboard: push expected reads on handshakes, pop on rvalid, check memory command port.
  task automatic monitor();
    logic          exp_known;
    logic          exp_we;
    logic          chk_addr;
    logic          chk_wdata;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    rsp_t          r;
    exp_known = 1'b0;
    exp_we = 1'b0; chk_addr = 1'b0; chk_wdata = 1'b0; exp_addr = '0; exp_wdata = '0;
    for (int a = 0; a < (1<<AW); a++) shadow[a] = init_word(a);
    forever begin
      @(negedge clk);
      if (exp_known) begin
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (chk_addr) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (chk_wdata) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
      chk("single_gnt", 32'(f_gnt & l_gnt), 0);
      chk("f_gnt_without_req", 32'(f_gnt & ~f_req), 0);
      chk("l_gnt_without_req", 32'(l_gnt & ~l_req), 0);
      if (rst) begin
        chk("rst_f_rvalid", 32'(f_rvalid), 0);
        chk("rst_l_rvalid", 32'(l_rvalid), 0);
        sbq.delete();
      end else begin
        chk("dual_rvalid", 32'(f_rvalid & l_rvalid), 0);
        if (f_rvalid || l_rvalid) begin
          if (sbq.size() == 0) begin
            chk("rvalid_unexpected", 32'(1), 0);
          end else begin
            r = sbq.pop_front();
            chk("rsp_owner_is_l", 32'(l_rvalid), 32'(r.is_l));
            chk("rsp_data", 32'(l_rvalid ? l_rdata : f_rdata), 32'(r.data));
            chk("rsp_cycle", 32'(cycle), 32'(r.due));
          end
        end
        while (sbq.size() > 0 && sbq[0].due < cycle) begin
          r = sbq.pop_front();
          chk("rsp_missing_due", 32'(cycle), 32'(r.due));
        end
        if (!f_rvalid) chk("f_rdata_idle_zero", 32'(f_rdata), 0);
        if (!l_rvalid) chk("l_rdata_idle_zero", 32'(l_rdata), 0);
        if (l_gnt) begin
          if (l_we) shadow[l_addr] = l_wdata;
          else sbq.push_back('{is_l: 1'b1, data: shadow[l_addr], due: cycle + RL + 1});
        end
        if (f_gnt) sbq.push_back('{is_l: 1'b0, data: shadow[f_addr], due: cycle + RL + 1});
      end
      exp_known = 1'b1;
      chk_addr = 1'b0;
      chk_wdata = 1'b0;
      exp_we = 1'b0;
      if (rst) begin
        chk_addr = 1'b1; chk_wdata = 1'b1; exp_addr = '0; exp_wdata = '0;
      end else if (l_gnt) begin
        chk_addr = 1'b1; exp_addr = l_addr; exp_we = l_we;
        chk_wdata = l_we; exp_wdata = l_wdata;
      end else if (f_gnt) begin
        chk_addr = 1'b1; exp_addr = f_addr;
      end
    end
  endtask

  task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr, input logic lw,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld, input logic h);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; halt = h;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_f_gnt"}, 32'(f_gnt), 0);
    chk({tag, "_l_gnt"}, 32'(l_gnt), 0);
    chk({tag, "_f_rvalid"}, 32'(f_rvalid), 0);
    chk({tag, "_l_rvalid"}, 32'(l_rvalid), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_f_rdata"}, 32'(f_rdata), 0);
    chk({tag, "_l_rdata"}, 32'(l_rdata), 0);
  endtask

  typedef struct {
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          exp_f;
    logic          exp_l;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic fr, input logic [AW-1:0] fa, input logic lr, input logic lw,
                              input logic [AW-1:0] la, input logic [DW-1:0] ld, input logic ef, input logic el);
    vt.push_back('{f_req: fr, f_addr: fa, l_req: lr, l_we: lw, l_addr: la, l_wdata: ld, exp_f: ef, exp_l: el});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rr;
`ifdef IMEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst = 1'b1;
    drive(1'b1, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Back-to-back fetch of 0x000..0x003.
    for (int a = 0; a < 4; a++) add(1'b1, AW'(a), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    // Loader writes 0xBEEF to 0x010, fetch reads it right after.
    add(1'b0, '0, 1'b1, 1'b1, 10'h010, 16'hBEEF, 1'b0, 1'b1);
    add(1'b1, 10'h010, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    add(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    add(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    // Six conflict cycles: alternating under round-robin, loader-only under fixed priority.
    for (int k = 0; k < 6; k++) begin
      if (rr) add(1'b1, 10'h005, 1'b1, 1'b0, 10'h006, '0, (k % 2) == 1, (k % 2) == 0);
      else    add(1'b1, 10'h005, 1'b1, 1'b0, 10'h006, '0, 1'b0, 1'b1);
    end
    add(1'b1, 10'h005, 1'b1, 1'b0, 10'h006, '0, 1'b0, 1'b1);
    add(1'b1, 10'h005, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    add(1'b0, '0, 1'b1, 1'b0, 10'h001, '0, 1'b0, 1'b1);
    add(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    add(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      step();
      drive(vt[i].f_req, vt[i].f_addr, vt[i].l_req, vt[i].l_we, vt[i].l_addr, vt[i].l_wdata, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_f_gnt", i), 32'(f_gnt), 32'(vt[i].exp_f));
      chk($sformatf("vec%0d_l_gnt", i), 32'(l_gnt), 32'(vt[i].exp_l));
    end
    repeat (4) step();

    // Halt one cycle after a fetch grant, drain, loader access while halted, release.
    step();
    drive(1'b1, 10'h011, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("halt_pre_f_gnt", 32'(f_gnt), 1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    chk("halt_req_halted", 32'(halted), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      drive(1'b1, 10'h012, 1'b0, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      chk($sformatf("drain%0d_f_gnt", k), 32'(f_gnt), 0);
      chk($sformatf("drain%0d_f_rvalid", k), 32'(f_rvalid), 32'(k == 1));
      chk($sformatf("drain%0d_halted", k), 32'(halted), 32'(k >= 2));
    end
    step();
    drive(1'b1, 10'h012, 1'b1, 1'b0, 10'h010, '0, 1'b1);
    @(negedge clk);
    chk("halt_l_gnt", 32'(l_gnt), 1);
    chk("halt_l_f_gnt", 32'(f_gnt), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      drive(1'b1, 10'h012, 1'b0, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      chk($sformatf("halt%0d_f_gnt", k), 32'(f_gnt), 0);
      chk($sformatf("halt%0d_halted", k), 32'(halted), 1);
      chk($sformatf("halt%0d_l_rvalid", k), 32'(l_rvalid), 32'(k == 2));
      if (l_rvalid) chk("halt_l_rdata", 32'(l_rdata), 32'h0000BEEF);
    end
    step();
    drive(1'b1, 10'h012, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("release_f_gnt_still_halted", 32'(f_gnt), 0);
    chk("release_halted", 32'(halted), 1);
    step();
    @(negedge clk);
    chk("resume_f_gnt", 32'(f_gnt), 1);
    chk("resume_halted", 32'(halted), 0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (5) step();

    // Reset pulse after two fetch grants: their responses must never appear.
    drive(1'b1, 10'h002, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("mrst_f_gnt0", 32'(f_gnt), 1);
    step();
    drive(1'b1, 10'h003, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("mrst_f_gnt1", 32'(f_gnt), 1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    step();
    check_all_zero("midreset");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_f_rvalid", k), 32'(f_rvalid), 0);
      chk($sformatf("post_rst%0d_l_rvalid", k), 32'(l_rvalid), 0);
    end
    step();
    drive(1'b1, 10'h001, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("post_rst_run_f_gnt", 32'(f_gnt), 1);
    chk("post_rst_halted", 32'(halted), 0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (6) step();
    chk("scoreboard_drained", 32'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
